// File: rtl/sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package : sequencer_pkg
// Purpose : Shared sizes and types for the drum-sequencer datapath.
// Rev     : 1.0  initial release
// ============================================================================
package sequencer_pkg;
  localparam int NUM_VOICES = 4;
  localparam int NUM_STEPS  = 8;
  localparam int STEP_W     = 3;
  localparam int BPM_W      = 8;

  typedef logic [STEP_W-1:0]     beat_idx_t;
  typedef logic [NUM_VOICES-1:0] voice_mask_t;
  typedef logic [NUM_STEPS-1:0]  step_pat_t;

  function automatic step_pat_t step_onehot(input beat_idx_t idx);
    step_pat_t r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction
endpackage
`default_nettype wire

// File: rtl/voice_channel.sv
`default_nettype none
// ============================================================================
// Module  : voice_channel
// Purpose : One sequencer voice: hit strobe -> trigger pulse, gate timer and,
//           with SEQ_TONE_EN defined, a gated square-wave tone.
// Rev     : 1.0  initial release
// ============================================================================
module voice_channel #(
  parameter int GATE_CYCLES = 2_500_000
`ifdef SEQ_TONE_EN
  , parameter int TONE_HALF = 25000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic play_i,
  input  logic hit_i,
  output logic trig_o,
  output logic gate_o
`ifdef SEQ_TONE_EN
  , output logic tone_o
`endif
);
  localparam int                CNT_W     = $clog2(GATE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  GATE_LOAD = CNT_W'(GATE_CYCLES);

  logic             trig_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A hit reloads the timer even while it is still running (retrigger).
  always_comb begin
    cnt_d = cnt_q;
    if (!play_i)              cnt_d = '0;
    else if (hit_i)           cnt_d = GATE_LOAD;
    else if (cnt_q != '0)     cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      trig_q <= hit_i & play_i;
      cnt_q  <= cnt_d;
    end
  end

  assign trig_o = trig_q & play_i;
  assign gate_o = (cnt_q != '0);

`ifdef SEQ_TONE_EN
  localparam int               PH_W    = $clog2(TONE_HALF + 1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(TONE_HALF - 1);

  logic [PH_W-1:0] ph_q, ph_d;
  logic            sq_q, sq_d;

  always_comb begin
    ph_d = ph_q;
    sq_d = sq_q;
    if (!play_i || (cnt_d == '0)) begin
      ph_d = '0;
      sq_d = 1'b0;
    end else if (hit_i) begin
      ph_d = '0;
      sq_d = 1'b1;
    end else if (ph_q == PH_LAST) begin
      ph_d = '0;
      sq_d = ~sq_q;
    end else begin
      ph_d = ph_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_q <= '0;
      sq_q <= 1'b0;
    end else begin
      ph_q <= ph_d;
      sq_q <= sq_d;
    end
  end

  assign tone_o = sq_q & gate_o;
`endif
endmodule
`default_nettype wire

// File: rtl/sequencer_datapath.sv
`default_nettype none
// ============================================================================
// Module  : sequencer_datapath
// Purpose : Pattern/BPM registers, eighth-note tempo generator and per-voice
//           hit decode for the drum-sequencer FSM. Define SEQ_TONE_EN to add
//           square-wave tones mixed onto audio_out.
// Rev     : 1.0  initial release
// ============================================================================
module sequencer_datapath
  import sequencer_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int GATE_CYCLES = 2_500_000
`ifdef SEQ_TONE_EN
  , parameter int TONE_HALF0 = 25000
  , parameter int TONE_HALF1 = 18000
  , parameter int TONE_HALF2 = 12000
  , parameter int TONE_HALF3 = 8000
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_ins1,
  input  logic                  ld_ins2,
  input  logic                  ld_ins3,
  input  logic                  ld_ins4,
  input  logic                  ld_bpm,
  input  logic                  play,
  input  logic [STEP_W-1:0]     timing,
  input  logic [7:0]            data_in,
  output logic                  beat_tick,
  output logic [NUM_VOICES-1:0] voice_trig,
  output logic [NUM_VOICES-1:0] voice_gate,
  output logic [NUM_STEPS-1:0]  step_led,
  output logic                  audio_out
);
  // 30 * CLK_HZ accumulated at bpm per cycle gives two ticks per beat.
  localparam int               THRESH   = CLK_HZ * 30;
  localparam int               ACC_W    = $clog2(THRESH + 256);
  localparam logic [ACC_W-1:0] THRESH_V = ACC_W'(THRESH);

  step_pat_t        pat_q [NUM_VOICES];
  logic [BPM_W-1:0] bpm_q;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic             tick_q, tick_d;
  step_pat_t        led_q;
  voice_mask_t      ld_vec, hit;
  logic             beat;

  assign ld_vec  = {ld_ins4, ld_ins3, ld_ins2, ld_ins1};
  assign acc_sum = acc_q + ACC_W'(bpm_q);
  assign beat    = tick_q & play;

  always_comb begin
    acc_d  = '0;
    tick_d = 1'b0;
    if (play) begin
      if (acc_sum >= THRESH_V) begin
        acc_d  = acc_sum - THRESH_V;
        tick_d = 1'b1;
      end else begin
        acc_d  = acc_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VOICES; i++) pat_q[i] <= '0;
      bpm_q  <= '0;
      acc_q  <= '0;
      tick_q <= 1'b0;
      led_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (ld_vec[i]) pat_q[i] <= data_in;
      end
      if (ld_bpm) bpm_q <= data_in;
      acc_q  <= acc_d;
      tick_q <= tick_d;
      led_q  <= play ? step_onehot(timing) : '0;
    end
  end

  // Timing is the FSM's pre-advance beat index on the tick cycle.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_VOICES; i++) hit[i] = beat & pat_q[i][timing];
  end

`ifdef SEQ_TONE_EN
  function automatic int tone_half(input int idx);
    case (idx)
      0:       return TONE_HALF0;
      1:       return TONE_HALF1;
      2:       return TONE_HALF2;
      default: return TONE_HALF3;
    endcase
  endfunction

  voice_mask_t tone;
  logic        audio_q;
`endif

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    voice_channel #(
      .GATE_CYCLES (GATE_CYCLES)
`ifdef SEQ_TONE_EN
      , .TONE_HALF (tone_half(gi))
`endif
    ) u_voice (
      .clk    (clk),
      .reset  (reset),
      .play_i (play),
      .hit_i  (hit[gi]),
      .trig_o (voice_trig[gi]),
      .gate_o (voice_gate[gi])
`ifdef SEQ_TONE_EN
      , .tone_o (tone[gi])
`endif
    );
  end

`ifdef SEQ_TONE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) audio_q <= 1'b0;
    else        audio_q <= |tone;
  end
  assign audio_out = audio_q;
`else
  assign audio_out = 1'b0;
`endif

  assign beat_tick = beat;
  assign step_led  = led_q;
endmodule
`default_nettype wire

// File: tb/tb_sequencer_datapath.sv
`default_nettype none
// ============================================================================
// Module  : tb_sequencer_datapath
// Purpose : Randomised + directed bench for sequencer_datapath; two instances
//           (slow tempo THRESH=3000, fast tempo THRESH=270) against a model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sequencer_datapath;
  localparam int GATE = 5;
  localparam int INV  = -1000;

  logic       clk = 1'b0;
  logic       reset, ld1, ld2, ld3, ld4, ld_bpm, play;
  logic [2:0] timing;
  logic [7:0] data_in;

  logic       tick_m, tick_f, aud_m, aud_f;
  logic [3:0] trig_m, trig_f, gate_m, gate_f;
  logic [7:0] led_m, led_f;

  always #5 clk = ~clk;

  sequencer_datapath #(.CLK_HZ(100), .GATE_CYCLES(GATE)) u_dut (
    .clk(clk), .reset(reset), .ld_ins1(ld1), .ld_ins2(ld2), .ld_ins3(ld3), .ld_ins4(ld4),
    .ld_bpm(ld_bpm), .play(play), .timing(timing), .data_in(data_in),
    .beat_tick(tick_m), .voice_trig(trig_m), .voice_gate(gate_m), .step_led(led_m),
    .audio_out(aud_m));

  sequencer_datapath #(.CLK_HZ(9), .GATE_CYCLES(GATE)) u_fast (
    .clk(clk), .reset(reset), .ld_ins1(ld1), .ld_ins2(ld2), .ld_ins3(ld3), .ld_ins4(ld4),
    .ld_bpm(ld_bpm), .play(play), .timing(timing), .data_in(data_in),
    .beat_tick(tick_f), .voice_trig(trig_f), .voice_gate(gate_f), .step_led(led_f),
    .audio_out(aud_f));

  // Reference model: running bpm total per instance, ticks when total/THRESH steps up.
  int         thr [2] = '{3000, 270};
  logic [7:0] m_pat [4];
  logic [7:0] m_bpm;
  longint     m_tot [2];
  bit         m_tick [2];
  int         m_last [2][4];
  logic [7:0] m_led;
  int         cyc = 0;
  int         n_vec = 0, n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 4; v++) m_pat[v] = '0;
    m_bpm = '0;
    m_led = '0;
    for (int d = 0; d < 2; d++) begin
      m_tot[d]  = 0;
      m_tick[d] = 1'b0;
      for (int v = 0; v < 4; v++) m_last[d][v] = INV;
    end
  endtask

  task automatic model_edge();
    longint nt;
    cyc++;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      if (m_tick[d] && play)
        for (int v = 0; v < 4; v++) if (m_pat[v][timing]) m_last[d][v] = cyc;
      if (!play)
        for (int v = 0; v < 4; v++) m_last[d][v] = INV;
      if (play) begin
        nt        = m_tot[d] + longint'(m_bpm);
        m_tick[d] = (nt / thr[d]) != (m_tot[d] / thr[d]);
        m_tot[d]  = nt;
      end else begin
        m_tot[d]  = 0;
        m_tick[d] = 1'b0;
      end
    end
    if (ld1) m_pat[0] = data_in;
    if (ld2) m_pat[1] = data_in;
    if (ld3) m_pat[2] = data_in;
    if (ld4) m_pat[3] = data_in;
    if (ld_bpm) m_bpm = data_in;
    m_led = play ? (8'd1 << timing) : 8'd0;
  endtask

  task automatic check_dut(input int d, input logic tk, input logic [3:0] tr, input logic [3:0] gt,
                           input logic [7:0] ld, input logic au);
    logic [3:0] etr, egt;
    string      p;
    p = (d == 0) ? "main" : "fast";
    for (int v = 0; v < 4; v++) begin
      etr[v] = play && (m_last[d][v] == cyc);
      egt[v] = (m_last[d][v] != INV) && ((cyc - m_last[d][v]) < GATE);
    end
    check_val({p, ".beat_tick"},  32'(tk), 32'(m_tick[d] & play));
    check_val({p, ".voice_trig"}, 32'(tr), 32'(etr));
    check_val({p, ".voice_gate"}, 32'(gt), 32'(egt));
    check_val({p, ".step_led"},   32'(ld), 32'(m_led));
`ifndef SEQ_TONE_EN
    check_val({p, ".audio_out"},  32'(au), 32'd0);
`endif
  endtask

  task automatic check_all();
    check_dut(0, tick_m, trig_m, gate_m, led_m, aud_m);
    check_dut(1, tick_f, trig_f, gate_f, led_f, aud_f);
  endtask

  // One clock: the FSM stand-in advances timing on the edge closing a tick cycle.
  task automatic step();
    bit adv;
    adv = m_tick[0] && play;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (adv) timing = timing + 3'd1;
  endtask

  task automatic load(input int which, input logic [7:0] v);
    data_in = v;
    case (which)
      1: ld1 = 1'b1;
      2: ld2 = 1'b1;
      3: ld3 = 1'b1;
      4: ld4 = 1'b1;
      default: ld_bpm = 1'b1;
    endcase
    step();
    {ld1, ld2, ld3, ld4, ld_bpm} = '0;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    step();
    #2;
    reset = 1'b1;
    play  = 1'b0;
  endtask

  initial begin
    int  cnt, c0, c1, c2, c3, n;
    bit  found;
    reset = 1'b0; play = 1'b0; timing = '0; data_in = '0;
    {ld1, ld2, ld3, ld4, ld_bpm} = '0;
    model_reset();
    step(); step();
    #2 reset = 1'b1;

    load(1, 8'b0101_0101); load(2, 8'h00); load(3, 8'hFF); load(4, 8'h80); load(5, 8'd150);
    play = 1'b1; timing = '0;
    cnt = 0; c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    for (int i = 0; i < 330; i++) begin
      step();
      if (i < 200 && tick_m) cnt++;
      c0 += int'(trig_m[0]); c1 += int'(trig_m[1]);
      c2 += int'(trig_m[2]); c3 += int'(trig_m[3]);
    end
    check_val("ticks_in_200", cnt, 10);
    check_val("v0_trigs", c0, 8);
    check_val("v1_trigs", c1, 0);
    check_val("v2_trigs", c2, 16);
    check_val("v3_trigs", c3, 2);

    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin step(); found = trig_m[2]; end
    check_val("wait_trig2", 32'(found), 32'd1);
    step();
    play = 1'b0;
    step();
    check_val("gate_after_stop", 32'(gate_m), 32'd0);
    check_val("led_after_stop", 32'(led_m), 32'd0);
    check_val("tick_after_stop", 32'(tick_m), 32'd0);
    play = 1'b1; timing = '0;
    n = 0; found = 0;
    for (int i = 1; i <= 40 && !found; i++) begin step(); if (tick_m) begin found = 1; n = i; end end
    check_val("replay_first_tick", n, 20);

    play = 1'b0; step();
    load(5, 8'd90);
    play = 1'b1; timing = '0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin step(); cnt += int'(gate_f[2]); end
    check_val("fast_gate2_held", cnt, 27);

    load(5, 8'd0);
    cnt = 0;
    for (int i = 0; i < 10000; i++) begin step(); cnt += int'(tick_m) + int'(tick_f); end
    check_val("bpm0_ticks", cnt, 0);
    data_in = 8'd255; ld_bpm = 1'b1;
    n = 0; found = 0;
    for (int i = 1; i <= 14 && !found; i++) begin
      step(); ld_bpm = 1'b0;
      if (tick_m) begin found = 1; n = i; end
    end
    check_val("bpm255_first_tick_ok", 32'(found && n <= 13), 32'd1);

    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin step(); found = |trig_m; end
    check_val("wait_trig_any", 32'(found), 32'd1);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      data_in = 8'($urandom);
      ld1 = ($urandom_range(15) == 0); ld2 = ($urandom_range(15) == 0);
      ld3 = ($urandom_range(15) == 0); ld4 = ($urandom_range(15) == 0);
      ld_bpm = ($urandom_range(31) == 0);
      if ($urandom_range(199) == 0) play = ~play;
      if (i == 5) play = 1'b1;
      step();
      {ld1, ld2, ld3, ld4, ld_bpm} = '0;
      if ($urandom_range(999) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
